// File: rtl/rand_sample_fifo.sv
// ---------------------------------------------------------------------------
// rand_sample_fifo
//   Downstream consumer of the 4-bit LFSR. A raw push-button is synchronized
//   and debounced; each clean press yields a single-cycle sample strobe that
//   captures rnd_in into a small FIFO. The FIFO head is presented on a
//   valid/ready interface. A sticky flag reports that an all-zero (LFSR
//   lock-up) value was ever captured.
//
//   Optional feature macro: RSF_OVERWRITE_EN
//     undefined : a push into a full FIFO is discarded; dropped counts it.
//     defined   : a push into a full FIFO overwrites the oldest entry, so the
//                 newest DEPTH samples are kept; dropped still counts it.
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   asynchronous, active-high reset
//   rnd_in     in   [W-1:0] LFSR value, captured on the sample strobe
//   btn        in   raw asynchronous button, active-high
//   out_valid  out  FIFO head is valid
//   out_data   out  [W-1:0] FIFO head sample (0 while empty)
//   out_ready  in   consumer accepts the head when out_valid & out_ready
//   count      out  [clog2(DEPTH):0] occupancy, 0..DEPTH
//   dropped    out  [7:0] samples lost to a full FIFO, saturating at 8'hFF
//   zero_err   out  sticky: a captured sample was zero; cleared only by rst
// ---------------------------------------------------------------------------
module rand_sample_fifo #(
  parameter int W          = 4,
  parameter int DEPTH      = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W-1:0]               rnd_in,
  input  logic                       btn,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 dropped,
  output logic                       zero_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(DEB_CYCLES - 1);
  localparam logic [CNTW-1:0] OCC_FULL = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_HELD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic            r_sync_p0;
  logic            r_sync_p1;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_strobe;

  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic [7:0]      r_dropped;
  logic            r_zero_err;

  logic            w_full;
  logic            w_valid;
  logic            w_push;
  logic            w_pop;
  logic            w_wr_en;
  logic            w_rd_adv;
  logic            w_drop;

  // ---- stage p0/p1: two-flop synchronizer for the raw button ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= btn;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // ---- debounce FSM on the synchronized level ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_strobe    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_sync_p1) begin
          w_state_nxt = S_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS: begin
        if (!r_sync_p1) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_MAX) begin
          // The only place a strobe is issued, so a held button cannot repeat.
          w_state_nxt = S_HELD;
          w_strobe    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_HELD: begin
        if (!r_sync_p1) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      S_RELEASE: begin
        if (r_sync_p1) begin
          w_state_nxt = S_HELD;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---- FIFO control ----
  assign w_full  = (r_count == OCC_FULL);
  assign w_valid = (r_count != '0);
  assign w_push  = w_strobe;
  assign w_pop   = w_valid & out_ready;

`ifdef RSF_OVERWRITE_EN
  // When full, the write lands on the oldest slot (wr_ptr == rd_ptr) and the
  // head moves on, so occupancy stays at DEPTH.
  assign w_wr_en  = w_push;
  assign w_drop   = w_push & w_full & ~w_pop;
  assign w_rd_adv = w_pop | w_drop;
`else
  // A simultaneous pop frees the slot, so only a push into a full FIFO with
  // no pop is lost.
  assign w_wr_en  = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;
  assign w_rd_adv = w_pop;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_dropped  <= '0;
      r_zero_err <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr_en && !w_rd_adv) begin
        r_count <= r_count + CNTW'(1);
      end else if (w_rd_adv && !w_wr_en) begin
        r_count <= r_count - CNTW'(1);
      end
      if (w_drop) begin
        r_dropped <= sat_inc8(r_dropped);
      end
      if (w_strobe && (rnd_in == '0)) begin
        r_zero_err <= 1'b1;
      end
    end
  end

  // Sample storage is datapath only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= rnd_in;
    end
  end

  assign out_valid = w_valid;
  assign out_data  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign count     = r_count;
  assign dropped   = r_dropped;
  assign zero_err  = r_zero_err;

endmodule

// File: tb/tb_rand_sample_fifo.sv
`timescale 1ns/1ps
module tb_rand_sample_fifo;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int DEB   = 16;
`ifdef RSF_OVERWRITE_EN
  localparam int OVR = 1;
`else
  localparam int OVR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] rnd_in = '0;
  logic         btn = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   count;
  logic [7:0]   dropped;
  logic         zero_err;

  rand_sample_fifo #(.W(W), .DEPTH(DEPTH), .DEB_CYCLES(DEB)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .rnd_in    (rnd_in),
    .btn       (btn),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .dropped   (dropped),
    .zero_err  (zero_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the button is accepted at a new level once the
  // synchronized value has differed from the accepted level for DEB+1
  // consecutive clock samples; acceptance of a high level is a capture.
  logic [W-1:0] mq[$];
  int           m_drop = 0;
  bit           m_zero = 1'b0;
  bit           m_h1 = 1'b0, m_h2 = 1'b0;
  bit           m_lvl = 1'b0;
  int           m_run = 0;

  task automatic model_step();
    bit b, stb, pop;
    if (rst) begin
      mq.delete();
      m_drop = 0; m_zero = 1'b0; m_h1 = 1'b0; m_h2 = 1'b0; m_lvl = 1'b0; m_run = 0;
    end else begin
      b = m_h2; m_h2 = m_h1; m_h1 = btn;
      stb = 1'b0;
      if (b != m_lvl) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_lvl = b; m_run = 0; stb = b;
        end
      end else begin
        m_run = 0;
      end
      pop = (mq.size() != 0) && out_ready;
      if (pop) void'(mq.pop_front());
      if (stb) begin
        if (rnd_in == '0) m_zero = 1'b1;
        if (mq.size() < DEPTH) begin
          mq.push_back(rnd_in);
        end else begin
          if (m_drop < 255) m_drop++;
          if (OVR != 0) begin
            void'(mq.pop_front());
            mq.push_back(rnd_in);
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  bit chk_en = 1'b0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("m_valid", out_valid, mq.size() != 0);
      check("m_count", count, mq.size());
      check("m_dropped", dropped, m_drop);
      check("m_zero_err", zero_err, m_zero);
      if (mq.size() != 0) check("m_data", out_data, mq[0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [W-1:0] v, input int hold, input int gap);
    rnd_in = v; btn = 1'b1; cyc(hold);
    btn = 1'b0; cyc(gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_dropped"}, dropped, 0);
    check({tag, "_zero"}, zero_err, 0);
    check({tag, "_data"}, out_data, 0);
  endtask

  task automatic do_reset();
    btn = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    #1 check_reset_outputs("rst_init");
    cyc(3);
    rst = 1'b0;
    chk_en = 1'b1;
    cyc(2);

    // Clean press: push edge is the 19th after btn rises.
    rnd_in = 4'hA; btn = 1'b1;
    cyc(18);
    check("press_pre_valid", out_valid, 0);
    cyc(1);
    check("press_valid", out_valid, 1);
    check("press_data", out_data, 4'hA);
    check("press_count", count, 1);
    cyc(21);
    btn = 1'b0;
    cyc(25);
    check("press_norepeat", count, 1);
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    check("press_popped", count, 0);

    // Bounce: never stable long enough.
    for (int i = 0; i < 10; i++) begin
      btn = ~btn; cyc(3);
    end
    btn = 1'b0;
    cyc(30);
    check("bounce_count", count, 0);

    // Fill and drain with one overflow.
    for (int i = 1; i <= 5; i++) press(W'(i), 20, 22);
    check("fill_count", count, 4);
    check("fill_dropped", dropped, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", out_data, 1 + i + OVR);
      cyc(1);
    end
    out_ready = 1'b0;
    check("drain_empty", count, 0);

    // Full FIFO with strobe and pop on the same edge.
    for (int i = 6; i <= 9; i++) press(W'(i), 20, 22);
    check("full_count", count, 4);
    rnd_in = 4'hC; btn = 1'b1;
    cyc(18);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    check("simul_count", count, 4);
    check("simul_dropped", dropped, 1);
    cyc(2); btn = 1'b0; cyc(22);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("simul_drain", out_data, (i < 3) ? 7 + i : 4'hC);
      cyc(1);
    end
    out_ready = 1'b0;

    // Lock-up detection and stickiness.
    rnd_in = 4'h0; btn = 1'b1;
    cyc(18);
    check("zero_pre", zero_err, 0);
    cyc(1);
    check("zero_set", zero_err, 1);
    cyc(2); btn = 1'b0; cyc(22);
    press(4'h5, 20, 22);
    check("zero_sticky", zero_err, 1);
    check("zero_count", count, 2);
    do_reset();
    check("zero_cleared", zero_err, 0);

    // Randomized run against the model, with one reset in the middle.
    for (int it = 0; it < 80; it++) begin
      btn = ~btn;
      n = $urandom_range(1, 40);
      for (int j = 0; j < n; j++) begin
        rnd_in = W'($urandom);
        out_ready = ($urandom_range(0, 3) == 0);
        cyc(1);
      end
      if (it == 40) do_reset();
    end
    btn = 1'b0; out_ready = 1'b1;
    cyc(30);
    check("final_empty", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
